// File: rtl/gpio_mmio_pkg.sv
// Register map and address decode shared by the GPIO MMIO block.
// Release-event bits live at REL_EVT_BIT when GPIO_MMIO_RELEASE_EVT_EN is defined.
package gpio_mmio_pkg;

  localparam logic [3:0] ADDR_SW      = 4'h0;
  localparam logic [3:0] ADDR_LED     = 4'h4;
  localparam logic [3:0] ADDR_BTN_LVL = 4'h8;
  localparam logic [3:0] ADDR_BTN_EVT = 4'hC;

  localparam int unsigned REL_EVT_BIT = 16;

  typedef enum logic [1:0] {
    REG_SW,
    REG_LED,
    REG_BTN_LVL,
    REG_BTN_EVT
  } reg_sel_e;

  // Only the word index matters; byte-lane bits never reach the decoder.
  function automatic reg_sel_e addr_to_sel(input logic [1:0] word);
    logic [3:0] a;
    a = {word, 2'b00};
    case (a)
      ADDR_SW:      return REG_SW;
      ADDR_LED:     return REG_LED;
      ADDR_BTN_LVL: return REG_BTN_LVL;
      ADDR_BTN_EVT: return REG_BTN_EVT;
      default:      return REG_SW;
    endcase
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level, edge pulses.
// The fall_o pulse exists only when GPIO_MMIO_RELEASE_EVT_EN is defined.
module gpio_debounce
  import gpio_mmio_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 20000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
`ifdef GPIO_MMIO_RELEASE_EVT_EN
  ,
  output logic fall_o
`endif
);

  localparam int unsigned CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]       sync_q;
  logic [1:0]       prime_q;
  logic             armed_q, armed_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             synced;
  logic             settle;

  assign synced = sync_q[1];
  assign settle = (synced != level_q) && (cnt_q == CNT_W'(DB_CYCLES - 1));

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (synced != level_q) begin
      if (settle) level_d = synced;
      else        cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // Presses count only after the synced input has been seen low once the
  // synchroniser holds real data, so a button held through reset stays silent.
  assign armed_d = armed_q | (prime_q[1] & ~synced);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      prime_q <= '0;
      armed_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      prime_q <= {prime_q[0], 1'b1};
      armed_q <= armed_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = settle & synced & armed_q;
`ifdef GPIO_MMIO_RELEASE_EVT_EN
  assign fall_o  = settle & ~synced;
`endif

endmodule

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: synchronised switches, LED register, debounced buttons, sticky W1C events.
// Define GPIO_MMIO_RELEASE_EVT_EN to add release events at BTN_EVT[16+i].
module gpio_mmio
  import gpio_mmio_pkg::*;
#(
  parameter int unsigned SW_W      = 16,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned N_BTN     = 1,
  parameter int unsigned DB_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        bus_addr,
  input  logic              bus_re,
  input  logic              bus_we,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ready,
  input  logic [SW_W-1:0]   sw_in,
  input  logic [N_BTN-1:0]  btn_in,
  output logic [LED_W-1:0]  led_out,
  output logic              btn_evt_any
);

  reg_sel_e         sel;
  logic             wr_led, wr_evt;
  logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
  logic [LED_W-1:0] led_q, led_d;
  logic [N_BTN-1:0] level, rise;
  logic [N_BTN-1:0] press_q, press_d;
  logic [31:0]      rd_word;
  logic [31:0]      rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             unused_bits;

  assign sel         = addr_to_sel(bus_addr[3:2]);
  assign wr_led      = bus_we && (sel == REG_LED);
  assign wr_evt      = bus_we && (sel == REG_BTN_EVT);
  assign unused_bits = ^{bus_addr[1:0], bus_wdata};

`ifdef GPIO_MMIO_RELEASE_EVT_EN
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] rel_q, rel_d;
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    gpio_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk_i  (clk),
      .rst_i  (rst),
      .btn_i  (btn_in[i]),
      .level_o(level[i]),
      .rise_o (rise[i])
`ifdef GPIO_MMIO_RELEASE_EVT_EN
      ,
      .fall_o (fall[i])
`endif
    );
  end

  assign led_d = wr_led ? bus_wdata[LED_W-1:0] : led_q;

  // Clear first, then OR in new events, so a same-cycle set survives the W1C.
  always_comb begin
    press_d = press_q;
    if (wr_evt) press_d = press_d & ~bus_wdata[N_BTN-1:0];
    press_d = press_d | rise;
  end

`ifdef GPIO_MMIO_RELEASE_EVT_EN
  always_comb begin
    rel_d = rel_q;
    if (wr_evt) rel_d = rel_d & ~bus_wdata[REL_EVT_BIT +: N_BTN];
    rel_d = rel_d | fall;
  end
`endif

  always_comb begin
    rd_word = '0;
    case (sel)
      REG_SW:      rd_word[SW_W-1:0]  = sw_s2_q;
      REG_LED:     rd_word[LED_W-1:0] = led_q;
      REG_BTN_LVL: rd_word[N_BTN-1:0] = level;
      REG_BTN_EVT: begin
        rd_word[N_BTN-1:0] = press_q;
`ifdef GPIO_MMIO_RELEASE_EVT_EN
        rd_word[REL_EVT_BIT +: N_BTN] = rel_q;
`endif
      end
      default:     rd_word = '0;
    endcase
  end

  assign rdata_d = bus_re ? rd_word : rdata_q;
  assign ready_d = bus_re | bus_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      led_q   <= '0;
      press_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      sw_s1_q <= sw_in;
      sw_s2_q <= sw_s1_q;
      led_q   <= led_d;
      press_q <= press_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

`ifdef GPIO_MMIO_RELEASE_EVT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rel_q <= '0;
    else     rel_q <= rel_d;
  end
  assign btn_evt_any = (|press_q) | (|rel_q);
`else
  assign btn_evt_any = |press_q;
`endif

  assign led_out   = led_q;
  assign bus_rdata = rdata_q;
  assign bus_ready = ready_q;

endmodule

// File: tb/tb_gpio_mmio.sv
// Self-checking bench for gpio_mmio (N_BTN=2, DB_CYCLES=4); honours GPIO_MMIO_RELEASE_EVT_EN.
module tb_gpio_mmio;

  localparam int unsigned SW_W  = 16;
  localparam int unsigned LED_W = 16;
  localparam int unsigned N_BTN = 2;
  localparam int unsigned DB    = 4;

`ifdef GPIO_MMIO_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        bus_addr;
  logic              bus_re, bus_we;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ready;
  logic [SW_W-1:0]   sw_in;
  logic [N_BTN-1:0]  btn_in;
  logic [LED_W-1:0]  led_out;
  logic              btn_evt_any;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_led;
  logic [31:0] exp_evt;

  gpio_mmio #(
    .SW_W     (SW_W),
    .LED_W    (LED_W),
    .N_BTN    (N_BTN),
    .DB_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_re     (bus_re),
    .bus_we     (bus_we),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ready  (bus_ready),
    .sw_in      (sw_in),
    .btn_in     (btn_in),
    .led_out    (led_out),
    .btn_evt_any(btn_evt_any)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Bus transactions start and end on a falling edge.
  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic rdy);
    bus_addr = a;
    bus_re   = 1'b1;
    @(negedge clk);
    bus_re = 1'b0;
    d      = bus_rdata;
    rdy    = bus_ready;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] wd, output logic rdy);
    bus_addr  = a;
    bus_wdata = wd;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we = 1'b0;
    rdy    = bus_ready;
  endtask

  // A pulse of len cycles registers a press only if len >= DB; release follows.
  task automatic btn_pulse(input int unsigned idx, input int unsigned len);
    btn_in[idx] = 1'b1;
    cyc(len);
    btn_in[idx] = 1'b0;
    cyc(DB + 6);
    if (len >= DB) begin
      exp_evt[idx] = 1'b1;
      if (REL_EN) exp_evt[16 + idx] = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        r;
    n_checks++;
    if ({led_out, bus_ready, bus_rdata, btn_evt_any} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: led=%h rdy=%b rdata=%h any=%b, want all 0",
               led_out, bus_ready, bus_rdata, btn_evt_any);
    end
    rst = 1'b0;
    cyc(2);
    bus_read(4'h4, d, r);
    n_checks++;
    if (d !== 32'h0 || r !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_read_led: got %h rdy=%b, want 00000000 rdy=1", d, r);
    end
    cyc(1);
    n_checks++;
    if (bus_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_pulse_width: got %b, want 0", bus_ready);
    end
  endtask

  task automatic test_led();
    logic [31:0] d, wd;
    logic        r;
    for (int k = 0; k < 5; k++) begin
      wd = (k == 0) ? 32'hFFFF_A5A5 : $urandom;
      bus_write(4'h4 | 4'($urandom_range(3, 0)), wd, r);
      exp_led = {16'h0, wd[15:0]};
      n_checks++;
      if (r !== 1'b1 || led_out !== exp_led[15:0]) begin
        n_fail++;
        $display("FAIL led_write[%0d]: led=%h rdy=%b, want led=%h rdy=1", k, led_out, r, exp_led[15:0]);
      end
      bus_read(4'h4 | 4'($urandom_range(3, 0)), d, r);
      n_checks++;
      if (d !== exp_led) begin
        n_fail++;
        $display("FAIL led_read[%0d]: got %h, want %h", k, d, exp_led);
      end
    end
  endtask

  task automatic test_sw();
    logic [31:0] d;
    logic [15:0] old_sw;
    logic        r;
    for (int k = 0; k < 3; k++) begin
      old_sw = sw_in;
      sw_in  = 16'($urandom);
      cyc(1);
      bus_read(4'h0, d, r);
      n_checks++;
      if (d !== {16'h0, old_sw}) begin
        n_fail++;
        $display("FAIL sw_sync_latency[%0d]: got %h, want %h", k, d, {16'h0, old_sw});
      end
      bus_read(4'h0, d, r);
      n_checks++;
      if (d !== {16'h0, sw_in}) begin
        n_fail++;
        $display("FAIL sw_read[%0d]: got %h, want %h", k, d, {16'h0, sw_in});
      end
    end
    bus_write(4'h0, $urandom, r);
    bus_write(4'h8, $urandom, r);
    bus_read(4'h4, d, r);
    n_checks++;
    if (d !== exp_led) begin
      n_fail++;
      $display("FAIL ro_write_ignored: led=%h, want %h", d, exp_led);
    end
  endtask

  task automatic test_debounce_timing();
    logic [31:0] d;
    logic        r;
    btn_in[1] = 1'b1;
    cyc(5);
    n_checks++;
    if (btn_evt_any !== 1'b0) begin
      n_fail++;
      $display("FAIL debounce_early: any=%b after 5 cycles, want 0", btn_evt_any);
    end
    cyc(1);
    n_checks++;
    if (btn_evt_any !== 1'b1) begin
      n_fail++;
      $display("FAIL debounce_on_time: any=%b after 6 cycles, want 1", btn_evt_any);
    end
    cyc(4);
    exp_evt = 32'h2;
    bus_read(4'h8, d, r);
    n_checks++;
    if (d !== 32'h2) begin
      n_fail++;
      $display("FAIL btn_lvl_press: got %h, want 00000002", d);
    end
    bus_read(4'hC, d, r);
    n_checks++;
    if (d !== exp_evt) begin
      n_fail++;
      $display("FAIL btn_evt_press: got %h, want %h", d, exp_evt);
    end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    logic        r;
    btn_in[1] = 1'b0;
    cyc(DB + 4);
    if (REL_EN) exp_evt[17] = 1'b1;
    bus_read(4'hC, d, r);
    n_checks++;
    if (d !== exp_evt) begin
      n_fail++;
      $display("FAIL release_evt: got %h, want %h", d, exp_evt);
    end
    bus_write(4'hC, 32'hFFFF_FFFF, r);
    exp_evt = '0;
    n_checks++;
    if (btn_evt_any !== 1'b0 || r !== 1'b1) begin
      n_fail++;
      $display("FAIL w1c_all: any=%b rdy=%b, want any=0 rdy=1", btn_evt_any, r);
    end
    // Press lands on the 6th edge; the W1C strobe is placed on that same edge.
    btn_in[1] = 1'b1;
    cyc(5);
    bus_write(4'hC, 32'h2, r);
    exp_evt = 32'h2;
    bus_read(4'hC, d, r);
    n_checks++;
    if (d !== exp_evt || btn_evt_any !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins: evt=%h any=%b, want %h any=1", d, btn_evt_any, exp_evt);
    end
    bus_write(4'hC, 32'h2, r);
    exp_evt = '0;
    bus_read(4'hC, d, r);
    n_checks++;
    if (d !== exp_evt || btn_evt_any !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_later: evt=%h any=%b, want 0 any=0", d, btn_evt_any);
    end
    btn_in[1] = 1'b0;
    cyc(DB + 4);
    bus_write(4'hC, 32'hFFFF_FFFF, r);
    exp_evt = '0;
  endtask

  task automatic test_bounce();
    logic [31:0] d, mask;
    logic        r;
    int unsigned idx, len;
    for (int k = 0; k < 8; k++) begin
      idx = (k == 0) ? 0 : $urandom_range(1, 0);
      len = (k == 0) ? 2 : $urandom_range(8, 1);
      btn_pulse(idx, len);
      bus_read(4'h8, d, r);
      n_checks++;
      if (d !== 32'h0) begin
        n_fail++;
        $display("FAIL bounce_lvl[%0d] btn%0d len%0d: got %h, want 00000000", k, idx, len, d);
      end
      bus_read(4'hC, d, r);
      n_checks++;
      if (d !== exp_evt) begin
        n_fail++;
        $display("FAIL bounce_evt[%0d] btn%0d len%0d: got %h, want %h", k, idx, len, d, exp_evt);
      end
      n_checks++;
      if (btn_evt_any !== (exp_evt != 0)) begin
        n_fail++;
        $display("FAIL bounce_any[%0d]: got %b, want %b", k, btn_evt_any, exp_evt != 0);
      end
      mask = $urandom;
      bus_write(4'hC, mask, r);
      exp_evt = exp_evt & ~mask;
    end
    bus_write(4'hC, 32'hFFFF_FFFF, r);
    exp_evt = '0;
  endtask

  task automatic test_rw_same_cycle();
    logic [31:0] a, b;
    bus_write(4'h4, $urandom, a[0]);
    a = {16'h0, led_out};
    b = $urandom;
    bus_addr  = 4'h4 | 4'($urandom_range(3, 0));
    bus_wdata = b;
    bus_re    = 1'b1;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_re = 1'b0;
    bus_we = 1'b0;
    exp_led = {16'h0, b[15:0]};
    n_checks++;
    if (bus_rdata !== a || led_out !== b[15:0] || bus_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_same_cycle: rdata=%h led=%h rdy=%b, want rdata=%h led=%h rdy=1",
               bus_rdata, led_out, bus_ready, a, b[15:0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        r;
    btn_in[0] = 1'b1;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    exp_led = '0;
    exp_evt = '0;
    n_checks++;
    if ({led_out, bus_ready, bus_rdata, btn_evt_any} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: led=%h rdy=%b rdata=%h any=%b, want all 0",
               led_out, bus_ready, bus_rdata, btn_evt_any);
    end
    rst = 1'b0;
    cyc(DB + 8);
    bus_read(4'h8, d, r);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL held_lvl: got %h, want 00000001", d);
    end
    bus_read(4'hC, d, r);
    n_checks++;
    if (d !== 32'h0 || btn_evt_any !== 1'b0) begin
      n_fail++;
      $display("FAIL held_no_evt: evt=%h any=%b, want 0 any=0", d, btn_evt_any);
    end
    btn_in[0] = 1'b0;
    cyc(DB + 4);
    if (REL_EN) exp_evt[16] = 1'b1;
    btn_pulse(0, DB + 2);
    bus_read(4'hC, d, r);
    n_checks++;
    if (d !== exp_evt) begin
      n_fail++;
      $display("FAIL repress_evt: got %h, want %h", d, exp_evt);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus_addr  = '0;
    bus_re    = 1'b0;
    bus_we    = 1'b0;
    bus_wdata = '0;
    sw_in     = '0;
    btn_in    = '0;
    exp_led   = '0;
    exp_evt   = '0;
    cyc(3);
    test_reset();
    test_led();
    test_sw();
    test_debounce_timing();
    test_w1c_collision();
    test_bounce();
    test_rw_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
